iter_divider: RTL and testbench

Multi-cycle integer divider for the MIPS32 execute stage that implements DIV/DIVU; it is the division counterpart to the single-cycle multiplier. It accepts one operation at a time and holds `busy` while it computes, so the pipeline can stall. The quotient and remainder are presented on `quotient`/`remainder`, which the HI/LO write logic loads as LO and HI. The core is a radix-2 restoring algorithm that runs on operand magnitudes and corrects signs once at the end.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/div_step.sv | 20 ++
 rtl/iter_divider.sv | 135 +++++++++++++
 tb/tb_iter_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the iterative divider: FSM encoding, iteration
// constants and a conditional two's-complement magnitude helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 5;

  // Magnitude of v when en is set (signed operand), otherwise v unchanged.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
module div_step (
  input  logic [31:0] rem_i,
  input  logic        msb_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [32:0] trial;

  // The remainder stays below the divisor, so bit 32 of the trial is its sign.
  assign shifted = {rem_i, msb_i};
  assign trial   = shifted - {1'b0, divisor_i};
  assign q_o     = ~trial[32];
  assign rem_o   = q_o ? trial[31:0] : shifted[31:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU unit: 32 restoring steps on magnitudes, then one sign
// fix-up cycle. Define DIV_EARLY_OUT_EN to finish b=0 and |a|<|b| in one cycle.
module iter_divider
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [31:0]          dvs_q, dvs_d;
  logic [31:0]          rem_q, rem_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [31:0]          quo_q, quo_d, rmd_q, rmd_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 load, step, early;
  logic [31:0]          mag_a, mag_b, step_rem;
  logic                 step_q;

  assign mag_a = abs32(a, is_signed);
  assign mag_b = abs32(b, is_signed);

`ifdef DIV_EARLY_OUT_EN
  assign early = (b == 32'd0) || (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  div_step u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[31]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = early ? FIX : CALC;
      CALC:    if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX) && !flush;
    load   = (state_q == IDLE) && start && !flush;
    step   = (state_q == CALC) && !flush;
  end

  // Early-out preloads the magnitude results so FIX applies the usual signs.
  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    if (load) begin
      cnt_d = '0;
      dvd_d = early ? ((b == 32'd0) ? 32'hFFFF_FFFF : 32'd0) : mag_a;
      dvs_d = mag_b;
      rem_d = early ? mag_a : 32'd0;
      sa_d  = is_signed & a[31];
      sb_d  = is_signed & b[31];
    end
    if (step) begin
      cnt_d = cnt_q + 1'b1;
      dvd_d = {dvd_q[30:0], step_q};
      rem_d = step_rem;
    end
    if (done_d) begin
      quo_d = (sa_q ^ sb_q) ? (~dvd_q + 32'd1) : dvd_q;
      rmd_d = sa_q ? (~rem_q + 32'd1) : rem_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus randomized
// back-to-back operations against an arithmetic reference model.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, flush;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  iter_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating division with the ISA's defined divide-by-zero and overflow results.
  task automatic ref_div(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = aa;
    sb = bb;
    if (bb == 0) begin
      q = (s && sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
      r = aa;
    end else if (s && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = aa / bb;
      r = aa % bb;
    end
  endtask

  function automatic int exp_latency(input logic [31:0] aa, input logic [31:0] bb, input logic s);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
    ma = (s && aa[31]) ? -aa : aa;
    mb = (s && bb[31]) ? -bb : bb;
    if (bb == 0 || ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Launches immediately (caller sits away from the clock edge), waits for done.
  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic s, input string tag);
    logic [31:0] eq, er;
    int lat;
    bit busy_ok;
    ref_div(aa, bb, s, eq, er);
    a = aa; b = bb; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = (busy === 1'b1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, "_lat"}, lat, exp_latency(aa, bb, s));
    check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
  endtask

  initial begin
    int dones;
    logic [31:0] ra, rb;
    logic rs;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, "divu_100_7");
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("hold_q", quotient, 32'd14);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    run_op(32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, "div_neg_by0");
    run_op(32'd3, 32'd10, 1'b0, "divu_3_10");
    run_op(32'd100, 32'd7, 1'b0, "divu_100_7b");

    // Flush mid-operation: no done, prior result held, next start works.
    a = 32'd50; b = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (9) begin @(posedge clk); #1; if (done) dones++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (done) dones++;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_no_done", dones, 0);
    check("flush_hold_q", quotient, 32'd14);
    check("flush_hold_r", remainder, 32'd2);
    run_op(32'd9, 32'd2, 1'b0, "after_flush");

    // Flush and start together: flush wins.
    a = 32'd77; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    check("flush_start_no_done", dones, 0);

    // Start while busy is ignored.
    a = 32'd100; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (80) begin @(posedge clk); #1; if (done) dones++; end
    check("busy_start_dones", dones, 1);
    check("busy_start_q", quotient, 32'd14);
    check("busy_start_r", remainder, 32'd2);

    // Asynchronous reset mid-operation.
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    check("midrst_no_done", dones, 0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       begin ra = $urandom_range(0, 100); rb = $urandom_range(101, 100000); end
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run_op(ra, rb, rs, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
